ecpri_mem_arb: RTL
==================

# ecpri_mem_arb

Arbiter and burst sequencer for the single-port eCPRI payload RAM. It shares the RAM between two requesters: the eCPRI receive path, which writes remote-memory-access payload (requester 0), and the eCPRI response builder, which reads payload back for read responses (requester 1). Each grant runs a complete fixed-length byte burst. Simultaneous requests are resolved round-robin.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM and payload byte width
- ADDR_WIDTH, 16, RAM address width
- LEN_WIDTH, 8, burst length width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_0  in  1  write-burst request from the rx path
- start_addr_0  in  ADDR_WIDTH  first RAM address of the write burst
- len_0  in  LEN_WIDTH  number of bytes to write
- wdata_0  in  DATA_WIDTH  current write byte
- wr_ack_0  out  1  wdata_0 is consumed at the next rising edge
- gnt_0 / done_0  out  1  burst-0 active / one-cycle completion pulse
- req_1  in  1  read-burst request from the response builder
- start_addr_1  in  ADDR_WIDTH  first RAM address of the read burst
- len_1  in  LEN_WIDTH  number of bytes to read
- rdata_1  out  DATA_WIDTH  read byte, equal to mem_rdata
- rvalid_1  out  1  rdata_1 is valid this cycle
- gnt_1 / done_1  out  1  burst-1 active / one-cycle completion pulse
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_we / mem_oe  out  1  RAM write enable / read enable
- mem_rdata  in  DATA_WIDTH  RAM read data, one cycle after mem_oe

## Operation
- States:
  - IDLE: no burst in progress.
  - WR: write burst for requester 0.
  - RD: read burst for requester 1.
  - RD_TAIL: one cycle to drain the last read.
  - FIN: one cycle that pulses the done flag.
- IDLE arbitration:
  - Only one request high: that requester wins.
  - Both requests high: the winner is the requester not granted last (last_gnt register). last_gnt resets to 1, so requester 0 wins the first tie.
- On grant:
  - start address and length are captured into internal registers; the beat counter k is cleared.
  - The next state is WR or RD, or FIN directly when the captured length is 0.
- WR: each cycle performs one beat.
  - Registered outputs: mem_addr ← start+k, mem_wdata ← wdata_0, mem_we ← 1.
  - wr_ack_0 is high throughout WR (Moore output).
  - After len beats the next state is FIN.
- RD: each cycle performs one beat.
  - Registered outputs: mem_addr ← start+k, mem_oe ← 1.
  - rvalid_1 is mem_oe delayed one cycle; rdata_1 = mem_rdata.
  - After len beats the next state is RD_TAIL, then FIN.
- FIN:
  - done of the granted requester pulses for one cycle; gnt drops; last_gnt is updated.
  - The next state is IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: 16'hFFFF + 1 wraps to 0.
- Requesters must hold req, start_addr and len until gnt rises.
- Deasserting req during a burst is ignored; the burst always completes.
- req held high after done is treated as a new request in IDLE.

## Timing
- Reset value of every output: 0. Reset also sets the state to IDLE and last_gnt to 1.
- reset_n low mid-burst: the burst is abandoned immediately, no done is issued, and the RAM enables drop asynchronously.
- Grant latency: req sampled high in IDLE at edge t, so gnt=1 from t+1.
- First mem_we or mem_oe is at t+2 (registered). mem_we/mem_oe are each high for exactly len consecutive cycles.
- Write of length len: gnt is high for len+1 cycles; done_0 pulses one cycle after the last mem_we.
- Read: rvalid_1 is high for len cycles, lagging mem_oe by one cycle; done_1 pulses the cycle after the last rvalid_1.
- At least one IDLE cycle separates consecutive bursts.
- mem_we and mem_oe are never high together. gnt_0 and gnt_1 are never high together.

## Structure
- Shared package ecpri_pkg holds:
  - the arbiter state encoding
  - requester ID constants (REQ_RX=0, REQ_RESP=1)
  - default DATA_WIDTH / ADDR_WIDTH / LEN_WIDTH
  - the eCPRI header offsets used by ecpri_rx and the response builder
- One sub-module is natural: ecpri_rr_pick, a 2-way round-robin selector (inputs req_0, req_1, last_gnt; outputs grant valid and grant index). It is purely combinational.
- The FSM, beat counter, address register and read-valid delay live in ecpri_mem_arb.

## Test plan
- Single write: req_0, start 16'h0100, len 4, wdata 8'hA0..A3. Expect:
  - mem_we high for 4 cycles at addresses 0100..0103 with data A0..A3
  - done_0 pulse once
  - RAM contents match
- Single read after that write: req_1, start 16'h0100, len 4. Expect:
  - rvalid_1 high for 4 cycles with rdata A0..A3
  - done_1 one cycle after the last valid
- Tie: req_0 and req_1 rise together, both held, repeated. Expect grants in the order 0, 1, 0, 1, and never overlapping gnt or enable signals.
- Wrap and zero length:
  - write start 16'hFFFE, len 3 → addresses FFFE, FFFF, 0000
  - len 0 → gnt for one cycle, done pulse, no mem_we/mem_oe
- Reset mid-burst: reset_n low at beat 2 of a len-8 write. Expect:
  - all outputs 0, no done
  - after release, the state is IDLE and requester 0 wins the next tie

Source files
------------

// File: rtl/ecpri_pkg.sv
// rtl/ecpri_pkg.sv - shared eCPRI types, default widths, requester IDs and header offsets
package ecpri_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_LEN_WIDTH  = 8;

   localparam logic REQ_RX   = 1'b0;
   localparam logic REQ_RESP = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD      = 3'd2,
      ST_RD_TAIL = 3'd3,
      ST_FIN     = 3'd4
   } arb_state_e;

   // Byte offsets in the common header and the remote-memory-access message body
   localparam int HDR_REV_OFS          = 0;
   localparam int HDR_MSG_TYPE_OFS     = 1;
   localparam int HDR_PAYLOAD_SIZE_OFS = 2;
   localparam int HDR_LEN              = 4;
   localparam int RMA_ID_OFS           = 4;
   localparam int RMA_RW_OFS           = 5;
   localparam int RMA_ELEM_ID_OFS      = 6;
   localparam int RMA_ADDR_OFS         = 8;
   localparam int RMA_LEN_OFS          = 14;
   localparam int RMA_PAYLOAD_OFS      = 16;
endpackage

// File: rtl/ecpri_mem_arb_if.sv
// rtl/ecpri_mem_arb_if.sv - requester and payload-RAM signals of the memory arbiter
interface ecpri_mem_arb_if import ecpri_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
   logic                  req_0;
   logic [ADDR_WIDTH-1:0] start_addr_0;
   logic [LEN_WIDTH-1:0]  len_0;
   logic [DATA_WIDTH-1:0] wdata_0;
   logic                  wr_ack_0;
   logic                  gnt_0;
   logic                  done_0;
   logic                  req_1;
   logic [ADDR_WIDTH-1:0] start_addr_1;
   logic [LEN_WIDTH-1:0]  len_1;
   logic [DATA_WIDTH-1:0] rdata_1;
   logic                  rvalid_1;
   logic                  gnt_1;
   logic                  done_1;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_we;
   logic                  mem_oe;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output req_0, start_addr_0, len_0, wdata_0, req_1, start_addr_1, len_1, mem_rdata,
      input  wr_ack_0, gnt_0, done_0, rdata_1, rvalid_1, gnt_1, done_1,
             mem_addr, mem_wdata, mem_we, mem_oe
   );

   modport slave (
      input  req_0, start_addr_0, len_0, wdata_0, req_1, start_addr_1, len_1, mem_rdata,
      output wr_ack_0, gnt_0, done_0, rdata_1, rvalid_1, gnt_1, done_1,
             mem_addr, mem_wdata, mem_we, mem_oe
   );
endinterface

// File: rtl/ecpri_rr_pick.sv
// rtl/ecpri_rr_pick.sv - two-way round-robin selector, purely combinational
module ecpri_rr_pick import ecpri_pkg::*; (
   input  logic req_0,
   input  logic req_1,
   input  logic last_gnt,
   output logic gnt_valid,
   output logic gnt_idx
);
   always_comb begin
      gnt_valid = req_0 | req_1;
      if (req_0 && req_1) begin
         gnt_idx = ~last_gnt;
      end else if (req_1) begin
         gnt_idx = REQ_RESP;
      end else begin
         gnt_idx = REQ_RX;
      end
   end
endmodule

// File: rtl/ecpri_mem_arb.sv
// rtl/ecpri_mem_arb.sv - payload-RAM arbiter running fixed-length write/read bursts
module ecpri_mem_arb import ecpri_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input logic            clk,
   input logic            reset_n,
   ecpri_mem_arb_if.slave bus
);
   arb_state_e            state_q, state_d;
   logic                  last_gnt_q, last_gnt_d;
   logic [ADDR_WIDTH-1:0] start_q, start_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  k_q, k_d;
   logic                  gnt_0_q, gnt_0_d;
   logic                  gnt_1_q, gnt_1_d;
   logic                  done_0_q, done_0_d;
   logic                  done_1_q, done_1_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  mem_we_q, mem_we_d;
   logic                  mem_oe_q, mem_oe_d;
   logic                  rvalid_q, rvalid_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  pick_valid;
   logic                  pick_idx;
   logic                  last_beat;

   ecpri_rr_pick u_pick (
      .req_0     (bus.req_0),
      .req_1     (bus.req_1),
      .last_gnt  (last_gnt_q),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   assign last_beat = (LEN_WIDTH'(k_q + 1'b1) == len_q);

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      start_d     = start_q;
      len_d       = len_q;
      k_d         = k_q;
      gnt_0_d     = gnt_0_q;
      gnt_1_d     = gnt_1_q;
      done_0_d    = 1'b0;
      done_1_d    = 1'b0;
      wr_ack_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_oe_d    = 1'b0;
      rvalid_d    = mem_oe_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               start_d = (pick_idx == REQ_RESP) ? bus.start_addr_1 : bus.start_addr_0;
               len_d   = (pick_idx == REQ_RESP) ? bus.len_1 : bus.len_0;
               k_d     = '0;
               gnt_0_d = (pick_idx == REQ_RX);
               gnt_1_d = (pick_idx == REQ_RESP);
               if (len_d == '0) begin
                  state_d = ST_FIN;
               end else if (pick_idx == REQ_RESP) begin
                  state_d = ST_RD;
               end else begin
                  state_d  = ST_WR;
                  wr_ack_d = 1'b1;
               end
            end
         end
         ST_WR: begin
            mem_addr_d  = start_q + ADDR_WIDTH'(k_q);
            mem_wdata_d = bus.wdata_0;
            mem_we_d    = 1'b1;
            k_d         = k_q + 1'b1;
            // wr_ack stays up only while another byte is still owed
            if (last_beat) begin
               state_d = ST_FIN;
            end else begin
               wr_ack_d = 1'b1;
            end
         end
         ST_RD: begin
            mem_addr_d = start_q + ADDR_WIDTH'(k_q);
            mem_oe_d   = 1'b1;
            k_d        = k_q + 1'b1;
            if (last_beat) begin
               state_d = ST_RD_TAIL;
            end
         end
         ST_RD_TAIL: begin
            state_d = ST_FIN;
         end
         ST_FIN: begin
            done_0_d   = gnt_0_q;
            done_1_d   = gnt_1_q;
            last_gnt_d = gnt_1_q;
            gnt_0_d    = 1'b0;
            gnt_1_d    = 1'b0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         last_gnt_q  <= REQ_RESP;
         start_q     <= '0;
         len_q       <= '0;
         k_q         <= '0;
         gnt_0_q     <= 1'b0;
         gnt_1_q     <= 1'b0;
         done_0_q    <= 1'b0;
         done_1_q    <= 1'b0;
         wr_ack_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_oe_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         start_q     <= start_d;
         len_q       <= len_d;
         k_q         <= k_d;
         gnt_0_q     <= gnt_0_d;
         gnt_1_q     <= gnt_1_d;
         done_0_q    <= done_0_d;
         done_1_q    <= done_1_d;
         wr_ack_q    <= wr_ack_d;
         mem_we_q    <= mem_we_d;
         mem_oe_q    <= mem_oe_d;
         rvalid_q    <= rvalid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.gnt_0     = gnt_0_q;
   assign bus.gnt_1     = gnt_1_q;
   assign bus.done_0    = done_0_q;
   assign bus.done_1    = done_1_q;
   assign bus.wr_ack_0  = wr_ack_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_oe    = mem_oe_q;
   assign bus.rvalid_1  = rvalid_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rdata_1   = bus.mem_rdata;
endmodule
